// File: rtl/stepper_decoder.sv
// stepper_decoder
//   Receive-side checker for the 3-bit stepper phase-code stream. One code is
//   sampled per Valid strobe; the block recovers step direction, tracks a
//   signed position, and flags transitions the stepper generator cannot emit.
//
// Ports
//   CP      in   system clock, rising edge
//   CR      in   synchronous active-high reset (priority over Valid)
//   Valid   in   one-cycle sample strobe
//   Code    in   3-bit phase code
//   Dir     out  direction of last accepted step (1 = forward)
//   Pos     out  signed W-bit position, wraps modulo 2^W
//   Step    out  one-cycle pulse per accepted step
//   Err     out  one-cycle pulse per illegal transition
//   Locked  out  high while tracking a legal stream
//   ErrCnt  out  saturating count of Err pulses
module stepper_decoder #(
  parameter int unsigned W = 8
) (
  input  logic                CP,
  input  logic                CR,
  input  logic                Valid,
  input  logic [2:0]          Code,
  output logic                Dir,
  output logic signed [W-1:0] Pos,
  output logic                Step,
  output logic                Err,
  output logic                Locked,
  output logic [3:0]          ErrCnt
);

  typedef enum logic [2:0] {
    StIdle,
    StSeen7,
    StSeen0,
    StTrack,
    StFault
  } state_e;

  localparam logic [W-1:0] PosOne = W'(1);

  state_e         state_q, state_d;
  logic [2:0]     p_q, p_d;
  logic [W-1:0]   pos_q, pos_d;
  logic           dir_q, dir_d;
  logic           locked_q, locked_d;
  logic           step_q, step_d;
  logic           err_q, err_d;
  logic [3:0]     errcnt_q, errcnt_d;

  // Next code on the forward ring 6->4->5->1->3->2->6.
  // Unused codes map to 7, which is intercepted before tracking and never matches.
  function automatic logic [2:0] fwd(input logic [2:0] c);
    case (c)
      3'd6:    fwd = 3'd4;
      3'd4:    fwd = 3'd5;
      3'd5:    fwd = 3'd1;
      3'd1:    fwd = 3'd3;
      3'd3:    fwd = 3'd2;
      3'd2:    fwd = 3'd6;
      default: fwd = 3'd7;
    endcase
  endfunction

  // Next code on the reverse ring 6->2->3->1->5->4->6.
  function automatic logic [2:0] bwd(input logic [2:0] c);
    case (c)
      3'd6:    bwd = 3'd2;
      3'd2:    bwd = 3'd3;
      3'd3:    bwd = 3'd1;
      3'd1:    bwd = 3'd5;
      3'd5:    bwd = 3'd4;
      3'd4:    bwd = 3'd6;
      default: bwd = 3'd7;
    endcase
  endfunction

  // State register
  always_ff @(posedge CP) begin
    if (CR) begin
      state_q  <= StIdle;
      p_q      <= 3'd0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      locked_q <= 1'b0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      step_q   <= step_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    locked_d = locked_q;
    step_d   = 1'b0;
    err_d    = 1'b0;
    errcnt_d = errcnt_q;

    if (Valid) begin
      if (Code == 3'd7) begin
        // 7 restarts the startup sequence from anywhere.
        state_d  = StSeen7;
        pos_d    = '0;
        locked_d = 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (Code == 3'd0) begin
              state_d = StSeen0;
            end else begin
              // Mid-stream sync: adopt the code as the reference phase.
              state_d  = StTrack;
              p_d      = Code;
              pos_d    = '0;
              locked_d = 1'b1;
            end
          end
          StSeen7: begin
            if (Code == 3'd0) begin
              state_d = StSeen0;
            end else begin
              err_d   = 1'b1;
              state_d = StFault;
            end
          end
          StSeen0: begin
            if (Code == 3'd6) begin
              state_d  = StTrack;
              p_d      = 3'd6;
              pos_d    = '0;
              locked_d = 1'b1;
            end else if (Code != 3'd0) begin
              err_d   = 1'b1;
              state_d = StFault;
            end
          end
          StTrack: begin
            if (Code == fwd(p_q)) begin
              p_d    = Code;
              pos_d  = pos_q + PosOne;
              dir_d  = 1'b1;
              step_d = 1'b1;
            end else if (Code == bwd(p_q)) begin
              p_d    = Code;
              pos_d  = pos_q - PosOne;
              dir_d  = 1'b0;
              step_d = 1'b1;
            end else if (Code != p_q) begin
              err_d    = 1'b1;
              locked_d = 1'b0;
              state_d  = StFault;
            end
          end
          StFault: ;
          default: state_d = StIdle;
        endcase
      end
    end

    if (err_d && (errcnt_q != 4'hF)) begin
      errcnt_d = errcnt_q + 4'd1;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    Dir    = dir_q;
    Pos    = pos_q;
    Step   = step_q;
    Err    = err_q;
    Locked = locked_q;
    ErrCnt = errcnt_q;
  end

endmodule

// File: tb/tb_stepper_decoder.sv
module tb_stepper_decoder;

  logic              CP;
  logic              CR;
  logic              Valid;
  logic [2:0]        Code;
  logic              Dir;
  logic signed [7:0] Pos;
  logic              Step;
  logic              Err;
  logic              Locked;
  logic [3:0]        ErrCnt;

  int checks = 0;
  int errors = 0;

  stepper_decoder #(.W(8)) dut (
    .CP     (CP),
    .CR     (CR),
    .Valid  (Valid),
    .Code   (Code),
    .Dir    (Dir),
    .Pos    (Pos),
    .Step   (Step),
    .Err    (Err),
    .Locked (Locked),
    .ErrCnt (ErrCnt)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  typedef struct {
    logic       cr;
    logic       valid;
    logic [2:0] code;
    logic       step;
    logic       err;
    logic       locked;
    logic       dir;
    logic [7:0] pos;
    logic [3:0] ec;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic cr, input logic valid, input logic [2:0] code,
                              input logic step, input logic err, input logic locked,
                              input logic dir, input logic [7:0] pos, input logic [3:0] ec);
    vec_t v;
    v.cr = cr; v.valid = valid; v.code = code; v.step = step; v.err = err;
    v.locked = locked; v.dir = dir; v.pos = pos; v.ec = ec;
    return v;
  endfunction

  task automatic add(input logic cr, input logic valid, input logic [2:0] code,
                     input logic step, input logic err, input logic locked,
                     input logic dir, input logic [7:0] pos, input logic [3:0] ec);
    vecs.push_back(mk(cr, valid, code, step, err, locked, dir, pos, ec));
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge CP);
    CR    = v.cr;
    Valid = v.valid;
    Code  = v.code;
    exp_q.push_back(v);
    @(posedge CP);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " step"},   {31'd0, Step},   {31'd0, e.step});
      check({tag, " err"},    {31'd0, Err},    {31'd0, e.err});
      check({tag, " locked"}, {31'd0, Locked}, {31'd0, e.locked});
      check({tag, " dir"},    {31'd0, Dir},    {31'd0, e.dir});
      check({tag, " pos"},    {24'd0, Pos},    {24'd0, e.pos});
      check({tag, " errcnt"}, {28'd0, ErrCnt}, {28'd0, e.ec});
      check({tag, " excl"},   {31'd0, Step & Err}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [2:0] ring [6];
  logic [2:0] ic;
  int         ec_exp;

  initial begin
    CR = 1'b1; Valid = 1'b0; Code = 3'd0;
    ring[0] = 3'd4; ring[1] = 3'd5; ring[2] = 3'd1;
    ring[3] = 3'd3; ring[4] = 3'd2; ring[5] = 3'd6;

    //   cr valid code  step err lock dir pos    ec
    // Reset and startup
    add(1, 0, 3'd0, 0, 0, 0, 0, 8'h00, 0);
    add(0, 1, 3'd7, 0, 0, 0, 0, 8'h00, 0);
    add(0, 1, 3'd0, 0, 0, 0, 0, 8'h00, 0);
    add(0, 1, 3'd6, 0, 0, 1, 0, 8'h00, 0);
    add(0, 1, 3'd4, 1, 0, 1, 1, 8'h01, 0);
    add(0, 0, 3'd3, 0, 0, 1, 1, 8'h01, 0);  // gated code change
    add(0, 1, 3'd5, 1, 0, 1, 1, 8'h02, 0);
    add(0, 1, 3'd1, 1, 0, 1, 1, 8'h03, 0);
    add(0, 1, 3'd3, 1, 0, 1, 1, 8'h04, 0);
    add(0, 1, 3'd2, 1, 0, 1, 1, 8'h05, 0);
    add(0, 1, 3'd6, 1, 0, 1, 1, 8'h06, 0);
    add(0, 0, 3'd7, 0, 0, 1, 1, 8'h06, 0);  // gated 7 must not restart
    // Reverse from a fresh lock at 6
    add(0, 1, 3'd7, 0, 0, 0, 1, 8'h00, 0);
    add(0, 1, 3'd0, 0, 0, 0, 1, 8'h00, 0);
    add(0, 1, 3'd6, 0, 0, 1, 1, 8'h00, 0);
    add(0, 1, 3'd2, 1, 0, 1, 0, 8'hFF, 0);
    add(0, 1, 3'd3, 1, 0, 1, 0, 8'hFE, 0);
    add(0, 1, 3'd1, 1, 0, 1, 0, 8'hFD, 0);
    add(0, 1, 3'd5, 1, 0, 1, 0, 8'hFC, 0);
    // Reset wins over Valid, then sync at 2 and walk to p=5, Pos=3
    add(1, 1, 3'd5, 0, 0, 0, 0, 8'h00, 0);
    add(0, 1, 3'd2, 0, 0, 1, 0, 8'h00, 0);
    add(0, 1, 3'd6, 1, 0, 1, 1, 8'h01, 0);
    add(0, 1, 3'd4, 1, 0, 1, 1, 8'h02, 0);
    add(0, 1, 3'd5, 1, 0, 1, 1, 8'h03, 0);
    // Reversal and hold
    add(0, 1, 3'd5, 0, 0, 1, 1, 8'h03, 0);
    add(0, 1, 3'd1, 1, 0, 1, 1, 8'h04, 0);
    add(0, 1, 3'd5, 1, 0, 1, 0, 8'h03, 0);
    add(0, 1, 3'd4, 1, 0, 1, 0, 8'h02, 0);
    // Illegal at p=4, fault ignores codes, recover via 7,0,6
    add(0, 1, 3'd3, 0, 1, 0, 0, 8'h02, 1);
    add(0, 1, 3'd6, 0, 0, 0, 0, 8'h02, 1);
    add(0, 1, 3'd4, 0, 0, 0, 0, 8'h02, 1);
    add(0, 1, 3'd7, 0, 0, 0, 0, 8'h00, 1);
    add(0, 1, 3'd0, 0, 0, 0, 0, 8'h00, 1);
    add(0, 1, 3'd6, 0, 0, 1, 0, 8'h00, 1);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Mid-stream sync then ErrCnt saturation
    apply(mk(1, 0, 3'd0, 0, 0, 0, 0, 8'h00, 0), "sat_rst");
    apply(mk(0, 1, 3'd1, 0, 0, 1, 0, 8'h00, 0), "sat_sync");
    for (int i = 0; i < 17; i++) begin
      // From p=1 code 4 is illegal; afterwards p=6 and 0 / 3 are illegal.
      ic     = (i == 0) ? 3'd4 : ((i == 1) ? 3'd0 : 3'd3);
      ec_exp = (i + 1 > 15) ? 15 : i + 1;
      apply(mk(0, 1, ic,   0, 1, 0, 0, 8'h00, 4'(ec_exp)), $sformatf("sat%0d_bad", i));
      apply(mk(0, 1, 3'd7, 0, 0, 0, 0, 8'h00, 4'(ec_exp)), $sformatf("sat%0d_7", i));
      apply(mk(0, 1, 3'd0, 0, 0, 0, 0, 8'h00, 4'(ec_exp)), $sformatf("sat%0d_0", i));
      apply(mk(0, 1, 3'd6, 0, 0, 1, 0, 8'h00, 4'(ec_exp)), $sformatf("sat%0d_6", i));
    end
    // Illegal after 7, and after a held 0; count stays saturated
    apply(mk(0, 1, 3'd7, 0, 0, 0, 0, 8'h00, 15), "s7_7");
    apply(mk(0, 1, 3'd3, 0, 1, 0, 0, 8'h00, 15), "s7_bad");
    apply(mk(0, 0, 3'd3, 0, 0, 0, 0, 8'h00, 15), "s7_gap");
    apply(mk(0, 1, 3'd7, 0, 0, 0, 0, 8'h00, 15), "s0_7");
    apply(mk(0, 1, 3'd0, 0, 0, 0, 0, 8'h00, 15), "s0_0");
    apply(mk(0, 1, 3'd0, 0, 0, 0, 0, 8'h00, 15), "s0_hold");
    apply(mk(0, 1, 3'd5, 0, 1, 0, 0, 8'h00, 15), "s0_bad");

    // Wrap: 127 forward steps, one more wraps to -128, one back returns to 127
    apply(mk(1, 0, 3'd0, 0, 0, 0, 0, 8'h00, 0), "wr_rst");
    apply(mk(0, 1, 3'd7, 0, 0, 0, 0, 8'h00, 0), "wr_7");
    apply(mk(0, 1, 3'd0, 0, 0, 0, 0, 8'h00, 0), "wr_0");
    apply(mk(0, 1, 3'd6, 0, 0, 1, 0, 8'h00, 0), "wr_6");
    for (int k = 0; k < 127; k++) begin
      apply(mk(0, 1, ring[k % 6], 1, 0, 1, 1, 8'(k + 1), 0), $sformatf("wr_f%0d", k));
    end
    apply(mk(0, 1, 3'd5, 1, 0, 1, 1, 8'h80, 0), "wr_over");
    apply(mk(0, 0, 3'd1, 0, 0, 1, 1, 8'h80, 0), "wr_gap");
    apply(mk(0, 1, 3'd4, 1, 0, 1, 0, 8'h7F, 0), "wr_under");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stepper_decoder.md
# stepper_decoder

Receive-side checker for the 3-bit stepper phase-code stream. Samples one code per strobe, recovers direction of travel (the Sin value that produced each step), tracks signed position, and flags any transition the stepper generator cannot produce. Sits between the stepper output pins (or a captured copy) and the display/monitor logic, on the fast system clock.

## Interface
- W, default 8: width of signed position counter.
- CP  in  1: system clock, rising edge.
- CR  in  1: reset, synchronous, active-high.
- Valid  in  1: one-cycle strobe; Code is sampled only when Valid=1.
- Code  in  3: phase code from stepper.
- Dir  out  1: direction of last accepted step; 1 = forward (Sin=1), 0 = reverse.
- Pos  out  W: signed two's-complement position.
- Step  out  1: one-cycle pulse per accepted step.
- Err  out  1: one-cycle pulse per illegal transition.
- Locked  out  1: 1 while tracking a legal stream.
- ErrCnt  out  4: saturating count of Err pulses.

## Operation
- Forward ring (Sin=1): 6→4→5→1→3→2→6. Reverse ring (Sin=0): 6→2→3→1→5→4→6. Startup path: 7→0→6.
- fwd(p) and bwd(p) are the next codes on the forward and reverse rings; p is the last accepted code.
- States: IDLE, SEEN7, SEEN0, TRACK, FAULT. All actions below occur only on a CP edge with Valid=1.
- Any state, Code=7: go SEEN7; Pos←0; Locked←0; no Step, no Err.
- IDLE:
  - Code=0: go SEEN0.
  - Code 1..6: go TRACK; p←Code; Pos←0; Locked←1; no Step (mid-stream sync).
- SEEN7:
  - Code=0: go SEEN0.
  - Code 1..6: Err; go FAULT.
- SEEN0:
  - Code=6: go TRACK; p←6; Pos←0; Locked←1; no Step.
  - Code=0: hold.
  - Code 1..5: Err; go FAULT.
- TRACK:
  - Code=fwd(p): Pos←Pos+1; Dir←1; Step.
  - Code=bwd(p): Pos←Pos−1; Dir←0; Step.
  - Code=p: hold; no Step, no Err (repeated sample).
  - Any other code, including 0: Err; Locked←0; go FAULT. Pos and Dir hold.
- FAULT: ignores every code except 7, which goes to SEEN7.
- Pos wraps modulo 2^W: +1 from 2^(W−1)−1 gives −2^(W−1), and the reverse. No flag is raised on wrap.
- ErrCnt increments on each Err and saturates at 15. It is cleared only by CR.
- Valid=0: all state and outputs hold. Step and Err are driven 0.

## Timing
- All outputs are registered. Effects of a sample appear the cycle after the Valid edge. Latency is 1 CP.
- Step and Err are exactly one CP wide and never asserted together.
- Back-to-back Valid on consecutive cycles is supported; each sample is evaluated independently.
- CR has priority over Valid. On the CR edge: state←IDLE, p←0, Pos←0, Dir←0, Locked←0, Step←0, Err←0, ErrCnt←0.
- CR asserted mid-stream discards p. The next valid code 1..6 re-syncs via IDLE with Pos=0.

## Test plan
- Startup: after CR, feed 7,0,6,4,5,1,3,2,6 → Locked=1 after the 6; Step ×6; Pos=6; Dir=1; Err never asserted.
- Reverse: from locked at 6, feed 2,3,1,5 → Pos=−4 (0xFC for W=8); Dir=0; four Step pulses.
- Reversal and hold: at p=5 with Pos=3, feed 5,1,5,4 → Step ×3; Pos sequence 3,4,3,2; Dir sequence 1,0,0.
- Illegal: at p=4, feed 3 → Err one cycle; Locked=0; ErrCnt=1; further 6,4 give no Step; then 7,0,6 → Locked=1, Pos=0.
- Mid-stream sync and saturation: CR, then Code=1 → Locked=1, Pos=0, no Step. Then force 17 illegal sequences (each illegal code followed by 7,0,6) → ErrCnt=15.
- Wrap and gating: W=8, Pos=127, forward step → Pos=−128. Code changes while Valid=0 → no output change.
